// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - reservation-station issue queue with CDB wakeup and registered issue bundle
// Optional: define RS_AGE_SEL_EN for oldest-first select (default lowest-index select).
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef FU_SEL_W
`define FU_SEL_W 3
`endif
`ifndef FU_SEL_NONE
`define FU_SEL_NONE 3'd0
`endif
`ifndef FU_SEL_ALU
`define FU_SEL_ALU 3'd1
`endif
`ifndef FU_SEL_MULT
`define FU_SEL_MULT 3'd2
`endif
`ifndef ZERO_REG
`define ZERO_REG 6'd31
`endif

module rs_issue_queue #(
    parameter int RS_NUM   = 8,
    parameter int RS_IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id2rs_vld_i,
    input  logic [`ROB_IDX_W-1:0] id2rs_rob_idx_i,
    input  logic [`PRF_IDX_W-1:0] id2rs_opa_tag_i,
    input  logic                  id2rs_opa_rdy_i,
    input  logic [`PRF_IDX_W-1:0] id2rs_opb_tag_i,
    input  logic                  id2rs_opb_rdy_i,
    input  logic [`PRF_IDX_W-1:0] id2rs_dest_tag_i,
    input  logic [31:0]           id2rs_IR_i,
    input  logic [`FU_SEL_W-1:0]  id2rs_sel_i,
    input  logic                  cdb_vld_i,
    input  logic [`PRF_IDX_W-1:0] cdb_tag_i,
    input  logic                  rob2rs_squash_i,
    input  logic                  fu2rs_mult_busy_i,
    output logic [`PRF_IDX_W-1:0] rs2prf_ra_idx_o,
    output logic [`PRF_IDX_W-1:0] rs2prf_rb_idx_o,
    input  logic [63:0]           prf2rs_ra_value_i,
    input  logic [63:0]           prf2rs_rb_value_i,
    output logic [`ROB_IDX_W-1:0] rs2fu_rob_idx_o,
    output logic [63:0]           rs2fu_ra_value_o,
    output logic [63:0]           rs2fu_rb_value_o,
    output logic [`PRF_IDX_W-1:0] rs2fu_dest_tag_o,
    output logic [31:0]           rs2fu_IR_o,
    output logic [`FU_SEL_W-1:0]  rs2fu_sel_o,
    output logic                  rs_full_o
);

    logic                  r_vld      [RS_NUM];
    logic                  r_opa_rdy  [RS_NUM];
    logic                  r_opb_rdy  [RS_NUM];
    logic [`PRF_IDX_W-1:0] r_opa_tag  [RS_NUM];
    logic [`PRF_IDX_W-1:0] r_opb_tag  [RS_NUM];
    logic [`PRF_IDX_W-1:0] r_dest_tag [RS_NUM];
    logic [`ROB_IDX_W-1:0] r_rob_idx  [RS_NUM];
    logic [31:0]           r_ir       [RS_NUM];
    logic [`FU_SEL_W-1:0]  r_sel      [RS_NUM];
`ifdef RS_AGE_SEL_EN
    logic [RS_IDX_W-1:0]   r_age      [RS_NUM];
    logic [RS_IDX_W-1:0]   w_best_age;
`endif

    logic                  w_full;
    logic [RS_IDX_W-1:0]   w_free_idx;
    logic                  w_disp_en;
    logic                  w_disp_opa_rdy;
    logic                  w_disp_opb_rdy;
    logic                  w_elig     [RS_NUM];
    logic                  w_sel_vld;
    logic [RS_IDX_W-1:0]   w_sel_idx;

    always_comb begin
        w_full     = 1'b1;
        w_free_idx = '0;
        for (int i = RS_NUM - 1; i >= 0; i--) begin
            if (!r_vld[i]) begin
                w_full     = 1'b0;
                w_free_idx = RS_IDX_W'(i);
            end
        end
    end

    assign rs_full_o = w_full;
    assign w_disp_en = id2rs_vld_i && !w_full && !rob2rs_squash_i;

    // Same-cycle CDB bypass so a tag broadcast at dispatch is not missed.
    assign w_disp_opa_rdy = id2rs_opa_rdy_i || (id2rs_opa_tag_i == `ZERO_REG) ||
                            (cdb_vld_i && (cdb_tag_i == id2rs_opa_tag_i));
    assign w_disp_opb_rdy = id2rs_opb_rdy_i || (id2rs_opb_tag_i == `ZERO_REG) ||
                            (cdb_vld_i && (cdb_tag_i == id2rs_opb_tag_i));

    always_comb begin
        for (int i = 0; i < RS_NUM; i++) begin
            w_elig[i] = r_vld[i] && r_opa_rdy[i] && r_opb_rdy[i] &&
                        !((r_sel[i] == `FU_SEL_MULT) && fu2rs_mult_busy_i);
        end
    end

    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
`ifdef RS_AGE_SEL_EN
        w_best_age = '0;
        for (int i = 0; i < RS_NUM; i++) begin
            if (w_elig[i] && (!w_sel_vld || (r_age[i] > w_best_age))) begin
                w_sel_vld  = 1'b1;
                w_sel_idx  = RS_IDX_W'(i);
                w_best_age = r_age[i];
            end
        end
`else
        for (int i = RS_NUM - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = RS_IDX_W'(i);
            end
        end
`endif
    end

    assign rs2prf_ra_idx_o = w_sel_vld ? r_opa_tag[w_sel_idx] : `ZERO_REG;
    assign rs2prf_rb_idx_o = w_sel_vld ? r_opb_tag[w_sel_idx] : `ZERO_REG;

    always_ff @(posedge clk) begin
        if (rst || rob2rs_squash_i) begin
            for (int i = 0; i < RS_NUM; i++) begin
                r_vld[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < RS_NUM; i++) begin
                if (r_vld[i] && cdb_vld_i) begin
                    if (r_opa_tag[i] == cdb_tag_i) r_opa_rdy[i] <= 1'b1;
                    if (r_opb_tag[i] == cdb_tag_i) r_opb_rdy[i] <= 1'b1;
                end
`ifdef RS_AGE_SEL_EN
                if (w_disp_en && r_vld[i] && (r_age[i] != '1)) r_age[i] <= r_age[i] + 1'b1;
`endif
            end
            if (w_sel_vld) r_vld[w_sel_idx] <= 1'b0;
            if (w_disp_en) begin
                r_vld[w_free_idx]      <= 1'b1;
                r_opa_rdy[w_free_idx]  <= w_disp_opa_rdy;
                r_opb_rdy[w_free_idx]  <= w_disp_opb_rdy;
                r_opa_tag[w_free_idx]  <= id2rs_opa_tag_i;
                r_opb_tag[w_free_idx]  <= id2rs_opb_tag_i;
                r_dest_tag[w_free_idx] <= id2rs_dest_tag_i;
                r_rob_idx[w_free_idx]  <= id2rs_rob_idx_i;
                r_ir[w_free_idx]       <= id2rs_IR_i;
                r_sel[w_free_idx]      <= id2rs_sel_i;
`ifdef RS_AGE_SEL_EN
                r_age[w_free_idx]      <= '0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rob2rs_squash_i) begin
            rs2fu_sel_o      <= `FU_SEL_NONE;
            rs2fu_dest_tag_o <= `ZERO_REG;
            rs2fu_rob_idx_o  <= '0;
            rs2fu_ra_value_o <= '0;
            rs2fu_rb_value_o <= '0;
            rs2fu_IR_o       <= '0;
        end else if (w_sel_vld) begin
            rs2fu_sel_o      <= r_sel[w_sel_idx];
            rs2fu_dest_tag_o <= r_dest_tag[w_sel_idx];
            rs2fu_rob_idx_o  <= r_rob_idx[w_sel_idx];
            rs2fu_ra_value_o <= prf2rs_ra_value_i;
            rs2fu_rb_value_o <= prf2rs_rb_value_i;
            rs2fu_IR_o       <= r_ir[w_sel_idx];
        end else begin
            rs2fu_sel_o      <= `FU_SEL_NONE;
            rs2fu_dest_tag_o <= '0;
            rs2fu_rob_idx_o  <= '0;
            rs2fu_ra_value_o <= '0;
            rs2fu_rb_value_o <= '0;
            rs2fu_IR_o       <= '0;
        end
    end

endmodule
